// File: rtl/pau_pkg.sv
// Shared definitions for the posit arithmetic unit: default field widths,
// producer source encoding and the request record carried through the split pipeline.
package pau_pkg;

    localparam int PAU_ES   = 3;
    localparam int PAU_BS   = 5;
    localparam int PAU_ID_W = 4;
    localparam int PAU_EXP_W = PAU_ES + PAU_BS + 1;

    localparam logic SRC_ADD = 1'b0;
    localparam logic SRC_MUL = 1'b1;

    typedef struct packed {
        logic [PAU_EXP_W-1:0] exp;
        logic [PAU_ID_W-1:0]  id;
        logic                 src;
    } req_t;

endpackage

// File: rtl/pau_regexp_split.sv
// Combinational split of a signed posit scale into exponent field, regime
// run length and regime sign. Shared by the arithmetic and decoder paths.
module pau_regexp_split #(
    parameter int ES = 3,
    parameter int BS = 5
) (
    input  logic signed [ES+BS:0] i_exp,
    output logic [ES-1:0]         o_e,
    output logic [BS-1:0]         o_r,
    output logic                  o_rneg
);

    logic          w_neg;
    logic [ES+BS:0] w_mag;
    logic [BS-1:0] w_hi;
    logic          w_inc;

    assign w_neg = i_exp[ES+BS];
    // Two's-complement magnitude; the most negative scale wraps mod 2^W.
    assign w_mag = w_neg ? $unsigned(-i_exp) : $unsigned(i_exp);
    assign w_hi  = w_mag[ES+BS-1:ES];
    assign w_inc = !w_neg || (w_mag[ES-1:0] != '0);

    assign o_e    = i_exp[ES-1:0];
    assign o_r    = w_inc ? w_hi + BS'(1) : w_hi;
    assign o_rneg = w_neg;

endmodule

// File: rtl/pau_regexp_arb.sv
// Round-robin arbiter sharing one regime/exponent split between the adder (port 0)
// and multiplier (port 1), followed by a 2-stage elastic pipeline to the packer.
module pau_regexp_arb
    import pau_pkg::*;
#(
    parameter int ES   = PAU_ES,
    parameter int BS   = PAU_BS,
    parameter int ID_W = PAU_ID_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [ES+BS:0]  req0_exp_i,
    input  logic [ID_W-1:0] req0_id_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [ES+BS:0]  req1_exp_i,
    input  logic [ID_W-1:0] req1_id_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [ES-1:0]   res_e_o,
    output logic [BS-1:0]   res_r_o,
    output logic            res_rneg_o,
    output logic [ID_W-1:0] res_id_o,
    output logic            res_src_o,
    output logic            busy_o
);

    logic            r_vld_p1;
    logic            r_vld_p2;
    logic            r_rr_last;
    req_t            r_req_p1;
    logic [ES-1:0]   r_e_p2;
    logic [BS-1:0]   r_r_p2;
    logic            r_rneg_p2;
    logic [ID_W-1:0] r_id_p2;
    logic            r_src_p2;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_arb_en;
    logic            w_gnt0;
    logic            w_gnt1;
    req_t            w_req_sel;
    logic [ES-1:0]   w_e;
    logic [BS-1:0]   w_r;
    logic            w_rneg;

    assign w_s2_adv = !r_vld_p2 || res_ready_i;
    assign w_s1_adv = !r_vld_p1 || w_s2_adv;
    assign w_arb_en = w_s1_adv && !flush_i;

    // rr_last == 1 favours port 0 on contention, and vice versa.
    assign w_gnt0 = w_arb_en && req0_valid_i && (!req1_valid_i || r_rr_last);
    assign w_gnt1 = w_arb_en && req1_valid_i && (!req0_valid_i || !r_rr_last);

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;

    always_comb begin
        w_req_sel.exp = req0_exp_i;
        w_req_sel.id  = req0_id_i;
        w_req_sel.src = SRC_ADD;
        if (w_gnt1) begin
            w_req_sel.exp = req1_exp_i;
            w_req_sel.id  = req1_id_i;
            w_req_sel.src = SRC_MUL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_last <= 1'b1;
        end else if (w_gnt0) begin
            r_rr_last <= 1'b0;
        end else if (w_gnt1) begin
            r_rr_last <= 1'b1;
        end
    end

    // Stage 1: granted request register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1 <= 1'b0;
            r_req_p1 <= '0;
        end else if (flush_i) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= w_gnt0 || w_gnt1;
            if (w_gnt0 || w_gnt1) begin
                r_req_p1 <= w_req_sel;
            end
        end
    end

    pau_regexp_split #(
        .ES (ES),
        .BS (BS)
    ) u_split (
        .i_exp  (r_req_p1.exp),
        .o_e    (w_e),
        .o_r    (w_r),
        .o_rneg (w_rneg)
    );

    // Stage 2: output register towards the packer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p2  <= 1'b0;
            r_e_p2    <= '0;
            r_r_p2    <= '0;
            r_rneg_p2 <= 1'b0;
            r_id_p2   <= '0;
            r_src_p2  <= 1'b0;
        end else if (flush_i) begin
            r_vld_p2 <= 1'b0;
        end else if (r_vld_p1 && w_s2_adv) begin
            r_vld_p2  <= 1'b1;
            r_e_p2    <= w_e;
            r_r_p2    <= w_r;
            r_rneg_p2 <= w_rneg;
            r_id_p2   <= r_req_p1.id;
            r_src_p2  <= r_req_p1.src;
        end else if (res_ready_i) begin
            r_vld_p2 <= 1'b0;
        end
    end

    assign res_valid_o = r_vld_p2;
    assign res_e_o     = r_e_p2;
    assign res_r_o     = r_r_p2;
    assign res_rneg_o  = r_rneg_p2;
    assign res_id_o    = r_id_p2;
    assign res_src_o   = r_src_p2;
    assign busy_o      = r_vld_p1 || r_vld_p2;

endmodule

// File: tb/tb_pau_regexp_arb.sv
// Directed bench for pau_regexp_arb: single-port splits, round-robin alternation,
// back-pressure stall, flush and asynchronous reset mid-stream.
module tb_pau_regexp_arb;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       req0_valid_i, req0_ready_o;
    logic [8:0] req0_exp_i;
    logic [3:0] req0_id_i;
    logic       req1_valid_i, req1_ready_o;
    logic [8:0] req1_exp_i;
    logic [3:0] req1_id_i;
    logic       res_valid_o, res_ready_i;
    logic [2:0] res_e_o;
    logic [4:0] res_r_o;
    logic       res_rneg_o;
    logic [3:0] res_id_o;
    logic       res_src_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    pau_regexp_arb dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_exp_i   (req0_exp_i),
        .req0_id_i    (req0_id_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_exp_i   (req1_exp_i),
        .req1_id_i    (req1_id_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_e_o      (res_e_o),
        .res_r_o      (res_r_o),
        .res_rneg_o   (res_rneg_o),
        .res_id_o     (res_id_o),
        .res_src_o    (res_src_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [3:0] id, input logic src,
                           input logic [2:0] e, input logic [4:0] r, input logic rneg);
        chk({tag, ".valid"}, res_valid_o, 1);
        chk({tag, ".id"},    res_id_o,    id);
        chk({tag, ".src"},   res_src_o,   src);
        chk({tag, ".e"},     res_e_o,     e);
        chk({tag, ".r"},     res_r_o,     r);
        chk({tag, ".rneg"},  res_rneg_o,  rneg);
    endtask

    task automatic run_one(input string tag, input logic port, input logic [8:0] exp_v,
                           input logic [3:0] id, input logic [2:0] e, input logic [4:0] r,
                           input logic rneg);
        if (port) begin
            req1_valid_i = 1'b1; req1_exp_i = exp_v; req1_id_i = id;
        end else begin
            req0_valid_i = 1'b1; req0_exp_i = exp_v; req0_id_i = id;
        end
        #1;
        chk({tag, ".ready0"}, req0_ready_o, !port);
        chk({tag, ".ready1"}, req1_ready_o, port);
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        chk({tag, ".lat1"}, res_valid_o, 0);
        tick();
        chk_res(tag, id, port, e, r, rneg);
        tick();
        chk({tag, ".drain"}, res_valid_o, 0);
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; res_ready_i = 1'b1;
        req0_valid_i = 1'b0; req0_exp_i = '0; req0_id_i = '0;
        req1_valid_i = 1'b0; req1_exp_i = '0; req1_id_i = '0;
        #2;
        chk("rst.valid", res_valid_o, 0);
        chk("rst.busy",  busy_o, 0);
        chk("rst.outs",  {res_e_o, res_r_o, res_rneg_o, res_id_o, res_src_o}, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single-port splits
        run_one("p0_zero", 1'b0, 9'h000, 4'd3, 3'd0, 5'd1, 1'b0);
        run_one("p1_13",   1'b1, 9'h013, 4'd5, 3'd3, 5'd3, 1'b0);
        run_one("p1_m8",   1'b1, 9'h1F8, 4'd6, 3'd0, 5'd1, 1'b1);
        run_one("p1_m9",   1'b1, 9'h1F7, 4'd7, 3'd7, 5'd2, 1'b1);

        // Contention: grants alternate starting at port 0 (last grant was port 1)
        begin
            logic [3:0] n0, n1;
            n0 = 4'd0; n1 = 4'd0;
            req0_exp_i = 9'h000; req1_exp_i = 9'h000;
            for (int c = 0; c < 6; c++) begin
                req0_valid_i = 1'b1; req0_id_i = n0;
                req1_valid_i = 1'b1; req1_id_i = 4'd8 + n1;
                #1;
                chk("rr.ready0", req0_ready_o, (c % 2) == 0);
                chk("rr.ready1", req1_ready_o, (c % 2) == 1);
                tick();
                if (c % 2 == 0) n0++; else n1++;
                if (c >= 1) begin
                    chk("rr.valid", res_valid_o, 1);
                    chk("rr.src",   res_src_o, (c - 1) % 2);
                    chk("rr.id",    res_id_o, ((c - 1) % 2) ? 8 + (c - 1) / 2 : (c - 1) / 2);
                end
            end
            req0_valid_i = 1'b0; req1_valid_i = 1'b0;
            tick();
            chk_res("rr_last", 4'd10, 1'b1, 3'd0, 5'd1, 1'b0);
            tick();
            chk("rr.drain", res_valid_o, 0);
        end

        // Back-pressure: two accepts, then stall with stable outputs
        res_ready_i = 1'b0;
        req0_valid_i = 1'b1; req0_id_i = 4'd4;  req0_exp_i = 9'h013;
        req1_valid_i = 1'b1; req1_id_i = 4'd12; req1_exp_i = 9'h1F7;
        #1;
        chk("st.c0.ready0", req0_ready_o, 1);
        chk("st.c0.ready1", req1_ready_o, 0);
        tick();
        req0_id_i = 4'd5;
        #1;
        chk("st.c1.ready0", req0_ready_o, 0);
        chk("st.c1.ready1", req1_ready_o, 1);
        chk("st.c1.valid",  res_valid_o, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("st.hold.ready0", req0_ready_o, 0);
            chk("st.hold.ready1", req1_ready_o, 0);
            chk_res("st.hold", 4'd4, 1'b0, 3'd3, 5'd3, 1'b0);
            tick();
        end
        res_ready_i = 1'b1;
        #1;
        chk("st.rel.ready0", req0_ready_o, 1);
        chk("st.rel.ready1", req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        chk_res("st.out1", 4'd12, 1'b1, 3'd7, 5'd2, 1'b1);
        tick();
        chk_res("st.out2", 4'd5, 1'b0, 3'd3, 5'd3, 1'b0);
        tick();
        chk("st.drain", busy_o, 0);

        // Flush with both stages full
        res_ready_i = 1'b0;
        req1_valid_i = 1'b1; req1_id_i = 4'd1; req1_exp_i = 9'h000;
        #1;
        chk("fl.ready1a", req1_ready_o, 1);
        tick();
        req1_id_i = 4'd2;
        #1;
        chk("fl.ready1b", req1_ready_o, 1);
        tick();
        req1_valid_i = 1'b0;
        flush_i = 1'b1;
        req0_valid_i = 1'b1; req0_id_i = 4'd6; req0_exp_i = 9'h000;
        #1;
        chk("fl.ready0", req0_ready_o, 0);
        chk("fl.ready1", req1_ready_o, 0);
        chk("fl.busy_pre", busy_o, 1);
        chk("fl.valid_pre", res_valid_o, 1);
        tick();
        flush_i = 1'b0; req0_valid_i = 1'b0;
        chk("fl.busy", busy_o, 0);
        chk("fl.valid", res_valid_o, 0);
        res_ready_i = 1'b1;
        run_one("fl_next", 1'b0, 9'h1F8, 4'd9, 3'd0, 5'd1, 1'b1);

        // Asynchronous reset mid-stream (last grant was port 0)
        req0_valid_i = 1'b1; req0_id_i = 4'd2;  req0_exp_i = 9'h013;
        req1_valid_i = 1'b1; req1_id_i = 4'd11; req1_exp_i = 9'h000;
        #1;
        chk("ar.ready0a", req0_ready_o, 0);
        chk("ar.ready1a", req1_ready_o, 1);
        tick();
        chk("ar.ready0b", req0_ready_o, 1);
        tick();
        chk("ar.valid_pre", res_valid_o, 1);
        chk("ar.busy_pre",  busy_o, 1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("ar.valid", res_valid_o, 0);
        chk("ar.busy",  busy_o, 0);
        chk("ar.id",    res_id_o, 0);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("ar.first0", req0_ready_o, 1);
        chk("ar.first1", req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick();
        chk_res("ar.out", 4'd2, 1'b0, 3'd3, 5'd3, 1'b0);
        tick();
        chk("ar.drain", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
